fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//   Read-side drain engine for FIFO_syn: drives rinc, tracks the fixed read latency of
//   the registered SRAM output, buffers returned words in a small skid buffer and
//   presents them as a valid/ready stream to the consumer in the read clock domain.
//   Sits between FIFO_syn (rclk side) and downstream datapath logic.
// PARAMETERS
//   WIDTH      8   data width; matches FIFO_syn WIDTH
//   READ_LAT   2   cycles from fifo_rinc asserted (cycle N) to word valid on fifo_rdata (cycle N+READ_LAT); >=1
//   BUF_DEPTH  4   skid buffer entries; >=2; full throughput requires BUF_DEPTH >= READ_LAT+2
// PORTS
//   clk          in   1      read-domain clock (FIFO_syn rclk)
//   rst          in   1      synchronous, active-high reset
//   rd_en        in   1      1 = allow new reads; 0 = stop issuing, finish in-flight, keep draining buffer
//   fifo_rinc    out  1      read request to FIFO_syn rinc
//   fifo_rdata   in   WIDTH  FIFO_syn rdata
//   fifo_rempty  in   1      FIFO_syn rempty
//   out_valid    out  1      out_data holds a valid word
//   out_data     out  WIDTH  head word of skid buffer
//   out_ready    in   1      consumer accepts; transfer when out_valid & out_ready
//   busy         out  1      1 while any read is in flight or buffer non-empty
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): fifo_rinc=0, out_valid=0, out_data=0, busy=0,
//     valid pipe, buffer pointers, count all 0. Mid-operation reset discards in-flight
//     reads and buffered words; no capture in the cycle after reset.
//   Issue: fifo_rinc = rd_en & ~fifo_rempty & (count + inflight < BUF_DEPTH);
//     combinational, uses registered count/inflight only (no same-cycle pop lookahead).
//     Never asserted while fifo_rempty=1 (FIFO_syn still latches rdata on any rinc).
//   Latency tracking: READ_LAT-bit shift register vpipe; vpipe[0] <= fifo_rinc,
//     vpipe[i] <= vpipe[i-1]; inflight = popcount(vpipe).
//   Capture: when vpipe[READ_LAT-1]=1, fifo_rdata written to buf[tail], tail advances.
//   Pop: out_valid & out_ready -> head advances. out_valid = (count != 0), out_data = buf[head]
//     registered-memory read (no combinational path fifo_rdata -> out_data).
//   Count: +1 on capture, -1 on pop; capture and pop in same cycle -> unchanged.
//   Pointers: $clog2(BUF_DEPTH) bits, wrap at BUF_DEPTH-1 -> 0 (non-power-of-2 allowed).
//   Overflow impossible by credit rule; capture into full buffer is a design error
//     (assertion in bench).
//   Order preserved: words leave in exactly the order fifo_rinc was issued.
//   out_valid, once high, stays high and out_data stable until popped.
//   busy = (count != 0) | (inflight != 0).
//   rd_en deassert: in-flight words still captured; buffer still drains.
//   Steady state (FIFO never empty, out_ready=1, BUF_DEPTH>=READ_LAT+2): 1 word/cycle;
//     first word out_valid in cycle N+READ_LAT+1 after first fifo_rinc in cycle N.
// CONFIGURATION
//   RD_STAT_EN defined: adds port beat_cnt out 16, count of popped words; reset 0,
//     +1 per transfer, wraps 16'hFFFF -> 0.
//   RD_STAT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1 rst, FIFO holds 8'h11,22,33, rd_en=1, out_ready=1 -> out_data 11,22,33 in order,
//     first out_valid 3 cycles after first fifo_rinc; busy=0 afterwards.
//   2 FIFO holds 10 words, out_ready=0 -> exactly BUF_DEPTH=4 rinc pulses, out_valid=1,
//     out_data=1st word held; out_ready=1 -> all 10 delivered, no loss/dup.
//   3 FIFO continuously non-empty, out_ready=1 -> fifo_rinc high every cycle,
//     one transfer per cycle after fill.
//   4 fifo_rempty=1 throughout -> fifo_rinc never asserted, out_valid=0, busy=0.
//   5 rst=1 with 2 in flight and 2 buffered -> next cycle out_valid=0, busy=0;
//     old words never appear on out_data.
//   6 RD_STAT_EN: 5 transfers -> beat_cnt=5; preload 16'hFFFF then 1 transfer -> 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for a synchronous FIFO: issues rinc under a credit limit, tracks the
// fixed SRAM read latency and presents returned words as a valid/ready stream. Optional: RD_STAT_EN.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int READ_LAT  = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef RD_STAT_EN
  output logic [15:0]      beat_cnt,
`endif
  output logic             busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LAT + 1);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic [READ_LAT-1:0] vpipe;
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [WIDTH-1:0]    mem [BUF_DEPTH];
  logic [SUM_W-1:0]    credit_used;
  logic                capture;
  logic                pop;

  function automatic logic [INF_W-1:0] popcount(input logic [READ_LAT-1:0] v);
    logic [INF_W-1:0] n;
    n = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      n = n + INF_W'(v[i]);
    end
    return n;
  endfunction

  // Pointers wrap explicitly so BUF_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Credit counts buffered plus in-flight words so every issued read has a slot waiting.
  assign inflight    = popcount(vpipe);
  assign credit_used = SUM_W'(count) + SUM_W'(inflight);
  assign fifo_rinc   = ~rst & rd_en & ~fifo_rempty & (credit_used < SUM_W'(BUF_DEPTH));

  assign capture   = vpipe[READ_LAT-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[head] : '0;
  assign busy      = out_valid | (inflight != '0);

  // Stage boundary: read-latency valid pipe, one bit per outstanding SRAM cycle.
  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= fifo_rinc;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= {vpipe[READ_LAT-2:0], fifo_rinc};
        end
      end
    end
  endgenerate

  // Stage boundary: skid buffer control.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (capture) begin
        tail <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      case ({capture, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[tail] <= fifo_rdata;
    end
  end

`ifdef RD_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model with fixed read latency, scoreboard of
// issued words, and a negedge monitor comparing the stream against that scoreboard.
module tb_fifo_rd_stream;
  localparam int WIDTH     = 8;
  localparam int READ_LAT  = 2;
  localparam int BUF_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rd_en = 1'b0;
  logic             fifo_rinc;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rempty = 1'b1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             busy;
`ifdef RD_STAT_EN
  logic [15:0]      beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .READ_LAT(READ_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
`ifdef RD_STAT_EN
    .beat_cnt(beat_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] dpipe[READ_LAT];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rinc_cnt = 0;
  int delivered = 0;
  int first_rinc = -1;
  int first_valid = -1;
  int beat_exp = 0;
  bit started = 0;

  assign fifo_rdata = dpipe[READ_LAT-1];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // FIFO_syn model: a read request pops the queue and the word appears READ_LAT cycles later.
  always @(posedge clk) begin
    logic [WIDTH-1:0] w;
    bit rinc_now;
    rinc_now = fifo_rinc;
    w = WIDTH'($urandom);
    if (rinc_now) begin
      check(fifo_q.size() != 0, "underflow", fifo_q.size(), 1);
      if (fifo_q.size() != 0) w = fifo_q.pop_front();
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc;
    end
    cyc++;
    if (rst) begin
      exp_q.delete();
      started = 1;
      beat_exp = 0;
    end else if (rinc_now) begin
      exp_q.push_back('{d: w, t: cyc});
    end
    for (int i = READ_LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
    dpipe[0] <= w;
    fifo_rempty <= (fifo_q.size() == 0);
  end

  // Monitor: a word is presentable READ_LAT edges after the edge that issued it.
  always @(negedge clk) begin
    if (started) begin
      int sz;
      bit ev;
      bit exp_rinc;
      sz = exp_q.size();
      ev = (sz > 0) && ((cyc - exp_q[0].t) >= READ_LAT);
      exp_rinc = !rst && rd_en && !fifo_rempty && (sz < BUF_DEPTH);
      check(fifo_rinc == exp_rinc, "rinc", fifo_rinc, exp_rinc);
      check(busy == (sz != 0), "busy", busy, sz != 0);
      check(out_valid == ev, "out_valid", out_valid, ev);
      check(sz <= BUF_DEPTH, "credit", sz, BUF_DEPTH);
`ifdef RD_STAT_EN
      check(beat_cnt == 16'(beat_exp), "beat_cnt", beat_cnt, beat_exp);
`endif
      if (out_valid && ev) begin
        check(out_data == exp_q[0].d, "out_data", out_data, exp_q[0].d);
        if (first_valid < 0) first_valid = cyc;
        if (out_ready && !rst) begin
          void'(exp_q.pop_front());
          delivered++;
          beat_exp++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    check(k < budget, name, k, budget);
  endtask

  task automatic clear_stats();
    rinc_cnt = 0;
    delivered = 0;
    first_rinc = -1;
    first_valid = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    for (int i = 0; i < READ_LAT; i++) dpipe[i] = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check(out_valid == 1'b0, "rst_valid", out_valid, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(out_data == '0, "rst_data", out_data, 0);
    check(fifo_rinc == 1'b0, "rst_rinc", fifo_rinc, 0);

    // Three words streamed through with the consumer always ready.
    clear_stats();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    out_ready = 1'b1;
    rd_en = 1'b1;
    drain(50, "t1_drain");
    tick(2);
    check(delivered == 3, "t1_count", delivered, 3);
    check(first_valid - first_rinc == READ_LAT + 1, "t1_latency", first_valid - first_rinc, READ_LAT + 1);
    check(busy == 1'b0, "t1_idle", busy, 0);

    // Stalled consumer: credit limits the reads to the buffer depth.
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH'(8'h40 + i));
    tick(15);
    check(rinc_cnt == BUF_DEPTH, "t2_rinc_pulses", rinc_cnt, BUF_DEPTH);
    check(out_valid == 1'b1, "t2_valid", out_valid, 1);
    check(out_data == 8'h40, "t2_head", out_data, 8'h40);
    out_ready = 1'b1;
    drain(80, "t2_drain");
    tick(2);
    check(delivered == 10, "t2_count", delivered, 10);

    // Continuously non-empty FIFO: one read and one transfer per cycle.
    for (int i = 0; i < 60; i++) fifo_q.push_back(WIDTH'(i));
    tick(6);
    clear_stats();
    tick(40);
    check(rinc_cnt == 40, "t3_rinc_rate", rinc_cnt, 40);
    check(delivered == 40, "t3_xfer_rate", delivered, 40);
    drain(100, "t3_drain");
    tick(2);

    // Empty FIFO throughout: nothing issued.
    clear_stats();
    tick(20);
    check(rinc_cnt == 0, "t4_rinc", rinc_cnt, 0);
    check(out_valid == 1'b0, "t4_valid", out_valid, 0);
    check(busy == 1'b0, "t4_busy", busy, 0);

    // Reset with two words buffered and two in flight.
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH'(8'h80 + i));
    k = 0;
    while (rinc_cnt == 0 && k < 20) begin
      tick(1);
      k++;
    end
    check(k < 20, "t5_start", k, 20);
    tick(3);
    check(out_valid == 1'b1, "t5_pre_valid", out_valid, 1);
    check(busy == 1'b1, "t5_pre_busy", busy, 1);
    rst = 1'b1;
    rd_en = 1'b0;
    tick(1);
    rst = 1'b0;
    check(out_valid == 1'b0, "t5_valid", out_valid, 0);
    check(busy == 1'b0, "t5_busy", busy, 0);
    for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(8'hC0 + i));
    rd_en = 1'b1;
    out_ready = 1'b1;
    drain(80, "t5_drain");
    tick(2);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rd_en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 20) fifo_q.push_back(WIDTH'($urandom));
      tick(1);
    end
    rst = 1'b0;
    rd_en = 1'b1;
    out_ready = 1'b1;
    drain(200, "t6_drain");
    tick(3);
    check(busy == 1'b0, "t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
